// File: rtl/vector_regfile_bcast.sv
// vector_regfile_bcast: banked lane VRF with operand-queue crossbar, full-width broadcast read and saturating conflict counter
module vector_regfile_bcast #(
  parameter int NrBanks = 8,
  parameter int NumWords = 64,
  parameter int DataWidth = 64,
  parameter int NrOperandQueues = 10,
  parameter int OutRegs = 0,
  parameter int CntWidth = 16,
  parameter int QIdxW = $clog2(NrOperandQueues)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrBanks-1:0]                   req_i,
  input  logic [NrBanks-1:0]                   wen_i,
  input  logic [NrBanks*$clog2(NumWords)-1:0]  addr_i,
  input  logic [NrBanks*DataWidth-1:0]         wdata_i,
  input  logic [NrBanks*DataWidth/8-1:0]       be_i,
  input  logic [NrBanks*QIdxW-1:0]             tgt_q_i,
  input  logic [NrBanks-1:0]                   bcast_i,
  output logic [NrOperandQueues*DataWidth-1:0] operand_o,
  output logic [NrOperandQueues-1:0]           operand_valid_o,
  output logic [NrBanks*DataWidth-1:0]         wide_o,
  output logic                                 wide_valid_o,
  output logic [QIdxW-1:0]                     wide_q_o,
  output logic                                 conflict_o,
  output logic [CntWidth-1:0]                  conflict_cnt_o
);
  localparam int AW = $clog2(NumWords);
  localparam int BW = DataWidth / 8;
  logic [DataWidth-1:0] mem [NrBanks][NumWords];
  logic [NrBanks*DataWidth-1:0] rdata;
  logic [NrBanks-1:0] rd_vld;
  logic [NrBanks*QIdxW-1:0] tgt_q;
  logic bcast;
  logic [NrOperandQueues*DataWidth-1:0] op_d;
  logic [NrOperandQueues-1:0] opv_d;
  logic cf_d;
  logic [NrBanks*DataWidth-1:0] wide_d;
  logic [QIdxW-1:0] wq_d;
  always_ff @(posedge clk_i)
    for (int b = 0; b < NrBanks; b++)
      if (req_i[b]) begin
        if (wen_i[b]) begin
          for (int j = 0; j < BW; j++)
            if (be_i[b*BW+j]) mem[b][addr_i[b*AW+:AW]][j*8+:8] <= wdata_i[b*DataWidth+j*8+:8];
        end else rdata[b*DataWidth+:DataWidth] <= mem[b][addr_i[b*AW+:AW]];
      end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rd_vld <= '0;
      bcast <= 1'b0;
      tgt_q <= '0;
    end else begin
      rd_vld <= req_i & ~wen_i;
      bcast <= &(req_i & ~wen_i & bcast_i);
      tgt_q <= tgt_q_i;
    end
  always_comb begin
    op_d = '0;
    opv_d = '0;
    cf_d = 1'b0;
    for (int b = 0; b < NrBanks; b++)
      for (int q = 0; q < NrOperandQueues; q++)
        if (rd_vld[b] && !bcast && tgt_q[b*QIdxW+:QIdxW] == QIdxW'(q)) begin
          cf_d = cf_d | opv_d[q];
          if (!opv_d[q]) op_d[q*DataWidth+:DataWidth] = rdata[b*DataWidth+:DataWidth];
          opv_d[q] = 1'b1;
        end
  end
  assign wide_d = bcast ? rdata : '0;
  assign wq_d = bcast ? tgt_q[QIdxW-1:0] : '0;
  generate
    if (OutRegs == 1) begin : g_out
      always_ff @(posedge clk_i)
        if (rst_i) begin
          operand_o <= '0;
          operand_valid_o <= '0;
          wide_o <= '0;
          wide_valid_o <= 1'b0;
          wide_q_o <= '0;
          conflict_o <= 1'b0;
        end else begin
          operand_o <= op_d;
          operand_valid_o <= opv_d;
          wide_o <= wide_d;
          wide_valid_o <= bcast;
          wide_q_o <= wq_d;
          conflict_o <= cf_d;
        end
    end else begin : g_comb
      assign operand_o = op_d;
      assign operand_valid_o = opv_d;
      assign wide_o = wide_d;
      assign wide_valid_o = bcast;
      assign wide_q_o = wq_d;
      assign conflict_o = cf_d;
    end
  endgenerate
  always_ff @(posedge clk_i)
    if (rst_i) conflict_cnt_o <= '0;
    else if (conflict_o && !(&conflict_cnt_o)) conflict_cnt_o <= conflict_cnt_o + CntWidth'(1);
endmodule

// File: tb/tb_vector_regfile_bcast.sv
// tb_vector_regfile_bcast: scoreboard bench driving OutRegs=0 and OutRegs=1 (CntWidth=2) instances in lockstep
module tb_vector_regfile_bcast;
  localparam int NB = 8, NW = 64, DW = 64, NQ = 10, QW = 4, AW = 6;
  localparam int RW = NQ + NQ*DW + 1, WW = 1 + QW + NB*DW;
  typedef struct { int at; int d; logic [RW-1:0] r; logic [WW-1:0] w; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NB-1:0] req = '0, wen = '0, bc = '0;
  logic [NB*AW-1:0] addr = '0;
  logic [NB*DW-1:0] wdata = '0;
  logic [NB*DW/8-1:0] be = '0;
  logic [NB*QW-1:0] tgt = '0;
  logic [NQ*DW-1:0] od0, od1;
  logic [NQ-1:0] ov0, ov1;
  logic [NB*DW-1:0] wd0, wd1;
  logic wv0, wv1, cf0, cf1;
  logic [QW-1:0] wq0, wq1;
  logic [15:0] cnt0, m0 = '0;
  logic [1:0] cnt1, m1 = '0;
  logic [RW-1:0] r0, r1;
  logic [WW-1:0] w0, w1;
  exp_t sb[$];
  logic [DW-1:0] mem_m [NB][NW];
  int ec = 0, passed = 0, total = 0;
  assign r0 = {ov0, od0, cf0};
  assign r1 = {ov1, od1, cf1};
  assign w0 = {wv0, wq0, wd0};
  assign w1 = {wv1, wq1, wd1};
  always #5 clk = ~clk;
  vector_regfile_bcast #(.OutRegs(0), .CntWidth(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .tgt_q_i(tgt), .bcast_i(bc), .operand_o(od0), .operand_valid_o(ov0),
    .wide_o(wd0), .wide_valid_o(wv0), .wide_q_o(wq0), .conflict_o(cf0), .conflict_cnt_o(cnt0));
  vector_regfile_bcast #(.OutRegs(1), .CntWidth(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .tgt_q_i(tgt), .bcast_i(bc), .operand_o(od1), .operand_valid_o(ov1),
    .wide_o(wd1), .wide_valid_o(wv1), .wide_q_o(wq1), .conflict_o(cf1), .conflict_cnt_o(cnt1));
  task automatic tick();
    @(posedge clk);
    ec++;
    #1;
  endtask
  task automatic idle();
    req = '0;
    wen = '0;
    bc = '0;
  endtask
  task automatic set_bank(int b, logic w, int a, logic [DW-1:0] d, logic [7:0] e, int q, logic c);
    req[b] = 1'b1;
    wen[b] = w;
    addr[b*AW+:AW] = AW'(a);
    wdata[b*DW+:DW] = d;
    be[b*8+:8] = e;
    tgt[b*QW+:QW] = QW'(q);
    bc[b] = c;
  endtask
  task automatic push_exp();
    int e = ec + 1;
    logic [NQ-1:0] v = '0;
    logic [NQ*DW-1:0] od = '0;
    logic cf = 1'b0;
    logic wv = 1'b0;
    logic [QW-1:0] wq = '0;
    logic [NB*DW-1:0] wd = '0;
    logic [AW-1:0] a;
    logic [QW-1:0] q;
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at >= e) sb.delete(i);
      m0 = '0;
      m1 = '0;
    end else begin
      wv = &(req & ~wen & bc);
      for (int b = 0; b < NB; b++) begin
        a = addr[b*AW+:AW];
        q = tgt[b*QW+:QW];
        if (req[b] && !wen[b]) begin
          if (wv) wd[b*DW+:DW] = mem_m[b][a];
          else if (q < NQ) begin
            if (v[q]) cf = 1'b1;
            else begin
              v[q] = 1'b1;
              od[q*DW+:DW] = mem_m[b][a];
            end
          end
        end
      end
      if (wv) wq = tgt[QW-1:0];
      for (int b = 0; b < NB; b++)
        if (req[b] && wen[b])
          for (int j = 0; j < 8; j++)
            if (be[b*8+j]) mem_m[b][addr[b*AW+:AW]][j*8+:8] = wdata[b*DW+j*8+:8];
      if (cf) begin
        m0 = (m0 == 16'hFFFF) ? m0 : m0 + 16'd1;
        m1 = (m1 == 2'd3) ? m1 : m1 + 2'd1;
      end
    end
    sb.push_back('{e, 0, {v, od, cf}, {wv, wq, wd}});
    sb.push_back('{e + 1, 1, {v, od, cf}, {wv, wq, wd}});
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int c = 0; c < 3; c++) begin
      push_exp();
      tick();
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL reset route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL reset wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
    total += 2;
    if (cnt0 !== 16'd0) $display("FAIL reset cnt0 got %0d exp 0", cnt0);
    else passed++;
    if (cnt1 !== 2'd0) $display("FAIL reset cnt1 got %0d exp 0", cnt1);
    else passed++;
    rst = 1'b0;
  endtask
  task automatic test_write_merge();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) set_bank(2, 1'b1, 5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 1'b0);
      if (c == 1) set_bank(2, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 1'b0);
      if (c == 2) set_bank(2, 1'b0, 5, 64'h0, 8'h00, 3, 1'b0);
      push_exp();
      tick();
      if (c == 2 || c == 3) begin
        total++;
        if ((c == 2 ? {ov0[3], od0[3*DW+:DW]} : {ov1[3], od1[3*DW+:DW]}) !== {1'b1, 64'hDEAD_BEEF_FFFF_FFFF})
          $display("FAIL merge_q3 dut%0d got %h exp %h", c - 2, c == 2 ? od0[3*DW+:DW] : od1[3*DW+:DW], 64'hDEAD_BEEF_FFFF_FFFF);
        else passed++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL write_merge route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL write_merge wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
  endtask
  task automatic test_bcast();
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int b = 0; b < NB; b++) begin
        if (c == 0) set_bank(b, 1'b1, 7, DW'(b), 8'hFF, 0, 1'b0);
        if (c == 1 || c == 2) set_bank(b, 1'b0, 7, 64'h0, 8'h00, b == 0 ? 4 : (b == 4 ? 0 : b), !(c == 2 && b == 6));
      end
      push_exp();
      tick();
      if (c == 1) begin
        total += 3;
        if ({wv0, wq0} !== {1'b1, 4'd4}) $display("FAIL bcast_flag got v=%b q=%0d exp v=1 q=4", wv0, wq0);
        else passed++;
        if (ov0 !== 10'h000) $display("FAIL bcast_opvalid got %h exp 000", ov0);
        else passed++;
        if (wd0[5*DW+:DW] !== 64'd5) $display("FAIL bcast_slice5 got %h exp 5", wd0[5*DW+:DW]);
        else passed++;
      end
      if (c == 2) begin
        total += 2;
        if ({wv0, ov0} !== {1'b0, 10'h0FF}) $display("FAIL partial_bcast got wv=%b ov=%h exp wv=0 ov=0ff", wv0, ov0);
        else passed++;
        if (od0[0+:DW] !== 64'd4) $display("FAIL partial_bcast_q0 got %h exp 4", od0[0+:DW]);
        else passed++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL bcast route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL bcast wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
  endtask
  task automatic test_oob();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin
        set_bank(0, 1'b0, 7, 64'h0, 8'h00, 12, 1'b0);
        set_bank(1, 1'b0, 7, 64'h0, 8'h00, 15, 1'b0);
        set_bank(2, 1'b0, 7, 64'h0, 8'h00, 10, 1'b0);
        set_bank(3, 1'b0, 7, 64'h0, 8'h00, 9, 1'b0);
      end
      push_exp();
      tick();
      if (c == 0) begin
        total++;
        if ({ov0, cf0} !== {10'h200, 1'b0}) $display("FAIL oob got ov=%h cf=%b exp ov=200 cf=0", ov0, cf0);
        else passed++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL oob route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL oob wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
  endtask
  task automatic test_conflict();
    for (int c = 0; c < 19; c++) begin
      idle();
      if (c == 0) for (int b = 0; b < NB; b++) set_bank(b, 1'b1, 1, {$urandom, $urandom}, 8'hFF, 0, 1'b0);
      if (c == 1 || (c >= 5 && c <= 7) || (c >= 11 && c <= 15)) begin
        set_bank(0, 1'b0, 1, 64'h0, 8'h00, 0, 1'b0);
        set_bank(1, 1'b0, 1, 64'h0, 8'h00, 2, 1'b0);
        set_bank(3, 1'b0, 1, 64'h0, 8'h00, 2, 1'b0);
        set_bank(5, 1'b0, 1, 64'h0, 8'h00, 2, 1'b0);
        set_bank(7, 1'b0, 1, 64'h0, 8'h00, 9, 1'b0);
      end
      push_exp();
      tick();
      if (c == 1) begin
        total++;
        if ({cf0, od0[2*DW+:DW]} !== {1'b1, mem_m[1][1]}) $display("FAIL conflict_q2 got cf=%b d=%h exp cf=1 d=%h", cf0, od0[2*DW+:DW], mem_m[1][1]);
        else passed++;
      end
      if (c == 4 || c == 10 || c == 18) begin
        total += 2;
        if (cnt0 !== (c == 4 ? 16'd1 : (c == 10 ? 16'd4 : 16'd9))) $display("FAIL conflict_cnt0 got %0d exp %0d", cnt0, c == 4 ? 1 : (c == 10 ? 4 : 9));
        else passed++;
        if (cnt1 !== m1) $display("FAIL conflict_cnt1_sat got %0d exp %0d", cnt1, m1);
        else passed++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL conflict route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL conflict wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 29; c++) begin
      idle();
      rst = (c == 16 || c == 17);
      for (int b = 0; b < NB; b++) begin
        if (c < 8) set_bank(b, 1'b1, c, {$urandom, $urandom}, 8'hFF, 0, 1'b0);
        if ((c >= 8 && c < 16) || (c >= 22 && c < 26))
          set_bank(b, 1'b0, $urandom_range(0, 7), 64'h0, 8'h00, $urandom_range(0, 15), 1'b0);
      end
      if (c >= 8 && c < 16 && $urandom_range(0, 3) == 0) bc = '1;
      push_exp();
      tick();
      if (c == 21) begin
        total += 2;
        if (cnt0 !== 16'd0) $display("FAIL b2b_cnt0_after_reset got %0d exp 0", cnt0);
        else passed++;
        if (cnt1 !== 2'd0) $display("FAIL b2b_cnt1_after_reset got %0d exp 0", cnt1);
        else passed++;
      end
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].at == ec && sb[i].d == d) begin
            total += 2;
            if ((d ? r1 : r0) !== sb[i].r) $display("FAIL back_to_back route dut%0d cyc %0d got %h exp %h", d, ec, d ? r1 : r0, sb[i].r);
            else passed++;
            if ((d ? w1 : w0) !== sb[i].w) $display("FAIL back_to_back wide dut%0d cyc %0d got %h exp %h", d, ec, d ? w1 : w0, sb[i].w);
            else passed++;
            sb.delete(i);
            break;
          end
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_write_merge();
    test_bcast();
    test_oob();
    test_conflict();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vector_regfile_bcast.md
Name: vector_regfile_bcast

Overview:
- Per-lane banked vector register file: NrBanks single-port banks, per-bank requests routed to NrOperandQueues operand queues.
- Adds a full-width broadcast read path for parallel LUT/permutation units.
- Adds an optional output pipeline stage and deterministic crossbar conflict handling with a saturating conflict counter.
- Sits between the lane's VRF arbiter and the operand queues.

Parameters:
- NrBanks, 8, number of banks; power of two, >= 2.
- NumWords, 64, words per bank.
- DataWidth, 64, bits per bank word; multiple of 8.
- NrOperandQueues, 10, number of operand-queue outputs.
- OutRegs, 0, extra output pipeline stages; legal values are 0 and 1.
- CntWidth, 16, width of the conflict counter.
- QIdxW, $clog2(NrOperandQueues), queue-index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NrBanks  per-bank access request.
- wen_i  in  NrBanks  per-bank write enable; valid only with req_i.
- addr_i  in  NrBanks*$clog2(NumWords)  per-bank word address.
- wdata_i  in  NrBanks*DataWidth  per-bank write data.
- be_i  in  NrBanks*DataWidth/8  per-bank byte enables.
- tgt_q_i  in  NrBanks*QIdxW  per-bank target operand queue for reads.
- bcast_i  in  NrBanks  per-bank broadcast-read request flag.
- operand_o  out  NrOperandQueues*DataWidth  per-queue read data.
- operand_valid_o  out  NrOperandQueues  per-queue valid.
- wide_o  out  NrBanks*DataWidth  broadcast data; bank b is in slice b.
- wide_valid_o  out  1  broadcast data valid.
- wide_q_o  out  QIdxW  broadcast target queue.
- conflict_o  out  1  crossbar conflict pulse.
- conflict_cnt_o  out  CntWidth  saturating conflict counter.

Behaviour:
- Reset (rst_i sampled high on a clock edge):
  - all valids, conflict_o, conflict_cnt_o, wide_q_o, pipeline registers and stage flags clear to 0 at that edge;
  - operand_o and wide_o read 0;
  - bank contents are not reset;
  - in-flight reads are dropped and produce no valid after reset deasserts.
- Write: req_i[b]&wen_i[b] updates only the enabled bytes at addr_i[b] at the clock edge. Writes produce no output.
- Read: req_i[b]&~wen_i[b] at cycle t. Data is valid at cycle t+1+OutRegs.
- Read of an address written in the same cycle cannot occur: the bank is single-port and the request is a write.
- Broadcast:
  - Condition: every bank has req_i&~wen_i&bcast_i in the same cycle.
  - Then wide_o = all bank rdata, wide_valid_o = 1 and wide_q_o = tgt_q_i[0], with the same latency as a normal read.
  - operand_valid_o stays all-zero for that cycle; broadcast reads never go through the crossbar.
  - If any bank lacks the condition, bcast_i is ignored for every bank and all reads route normally.
- Crossbar:
  - Each non-broadcast read goes to operand queue tgt_q_i[b].
  - If several banks target the same queue in one cycle, the lowest-index bank wins. The other banks' data is dropped.
  - conflict_o pulses for one cycle, aligned with the output cycle.
  - conflict_cnt_o increments by 1 per conflicting cycle (not per dropped bank) and saturates at all-ones.
- tgt_q_i >= NrOperandQueues: the read is dropped silently, with no valid and no conflict.
- Outputs with valid low read 0 (operand_o slice and wide_o).
- OutRegs=1: one full register stage is applied after routing. All outputs, including conflict_o and the counter update, are delayed by one cycle identically.
- Back-to-back reads every cycle: full throughput, with no bubbles in either OutRegs setting.

Test Plan:
- Write 0xDEAD_BEEF_0123_4567 (be all 1s) to bank 2, addr 5. Then write be=0x0F, data 0xFFFF_FFFF_FFFF_FFFF to the same address. Read it to queue 3 -> operand_o[3] = 0xDEAD_BEEF_FFFF_FFFF, valid at t+1 (OutRegs=0) and at t+2 (OutRegs=1).
- Fill addr 7 of bank b with value b. Read all banks with bcast_i=all 1s and tgt_q_i[0]=4 -> wide_valid_o=1, wide_o slice b = b, wide_q_o=4, operand_valid_o=0. Repeat with bcast_i[6]=0 -> wide_valid_o=0 and each bank routed normally.
- Banks 1, 3 and 5 read to queue 2 in one cycle -> operand_o[2] = bank 1 data, conflict_o=1, conflict_cnt_o 0->1. The same pattern for 3 consecutive cycles -> counter = 4.
- CntWidth=2, conflicts in 5 consecutive cycles -> counter holds at 3.
- Issue reads every cycle for 8 cycles, then assert rst_i while reads are in flight (OutRegs=1) -> no valid after reset deasserts, counter = 0, and previously written data is still readable.
- tgt_q_i = 12 with NrOperandQueues=10 -> no operand_valid_o and conflict_o=0.
